contador_carga_param: RTL
=========================

// Module: contador_carga_param
// PURPOSE
//   Parametrised loadable up/down counter with a programmable upper bound,
//   wrap or saturate mode, synchronous clear and cascade outputs.
//   Generalises the fixed 6-bit loadable up-counter, keeping its load/enable
//   semantics. Used as a timing/sequence counter and chained via tc for
//   wider counts.
// PARAMETERS
//   WIDTH     6    counter width in bits (>=2)
//   MAX_VAL   63   highest count value; count range 0..MAX_VAL (MAX_VAL <= 2^WIDTH-1)
//   SATURATE  0    0 = wrap at bounds, 1 = hold at bounds
//   RESET_VAL 0    value of out after reset and after clear (must be <= MAX_VAL)
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset (0 = reset asserted)
//   clear     in   1      synchronous clear to RESET_VAL
//   load      in   1      parallel load enable
//   data      in   WIDTH  parallel load value
//   enable    in   1      count enable
//   up_down   in   1      1 = count up, 0 = count down
//   out       out  WIDTH  current count (registered)
//   tc        out  1      terminal count, combinational, for cascading
//   wrap      out  1      registered one-cycle pulse: a wrap occurred
//   load_err  out  1      registered one-cycle pulse: load value was clamped
// BEHAVIOUR
//   - Reset (reset=0, async) forces out=RESET_VAL, wrap=0, load_err=0.
//     Release is synchronous to clk; the first count is on the first rising
//     edge with reset=1.
//   - Per rising edge, priority is clear > load > enable > hold. Unselected
//     actions are ignored that cycle.
//   - clear: out<=RESET_VAL, wrap<=0, load_err<=0.
//   - load: out<=data when data<=MAX_VAL, else out<=MAX_VAL with load_err<=1.
//     load_err<=0 otherwise. A load never raises wrap.
//   - enable, up_down=1:
//       out<MAX_VAL: out<=out+1.
//       out==MAX_VAL: out<=0 with wrap<=1 (SATURATE=0), or hold MAX_VAL
//       with wrap<=0 (SATURATE=1).
//   - enable, up_down=0:
//       out>0: out<=out-1.
//       out==0: out<=MAX_VAL with wrap<=1 (SATURATE=0), or hold 0
//       with wrap<=0 (SATURATE=1).
//   - out>MAX_VAL is unreachable. No arithmetic may overflow WIDTH bits:
//     the bound is compared before incrementing.
//   - wrap and load_err are high for exactly the cycle following the event
//     (coincident with the new out value). Otherwise they are 0.
//   - tc = enable & ~clear & ~load & (up_down ? out==MAX_VAL : out==0).
//     tc is valid in both modes and feeds the enable of the next stage.
//   - Latency: out reflects load/count/clear 1 clock after the edge;
//     tc reacts combinationally with 0 latency.
//   - Reset asserted mid-count aborts the count immediately. A pending
//     wrap/load_err pulse is cleared.
// TESTING
//   1. Reset: hold reset=0, toggle clk -> out=0, wrap=0, load_err=0.
//      Release; enable=1, up=1 -> out 0,1,2,3 on successive edges.
//   2. Wrap up (MAX_VAL=9): load 8, enable up -> out 9 (tc=1), then 0
//      with wrap=1 for one cycle, then 1 with wrap=0.
//   3. Wrap down (MAX_VAL=9): load 1, enable down -> 0 (tc=1), then 9
//      with wrap=1, then 8.
//   4. Saturate (SATURATE=1, MAX_VAL=63): load 62, up for 3 edges ->
//      63, 63, 63 with wrap=0 and tc=1. Repeat down from 1 -> 0, 0.
//   5. Priority/clamp (MAX_VAL=9): load=1, data=15 -> out=9, load_err=1
//      for one cycle. load+enable together -> load wins. clear+load ->
//      out=RESET_VAL.
//   6. Async reset mid-count: at out=5, drop reset between edges ->
//      out=0 immediately, before the next edge. Cascade two 4-bit
//      instances via tc -> combined count 0..255 wraps correctly.

Source files
------------

// File: rtl/contador_carga_param.sv
// contador_carga_param: loadable up/down counter with programmable bound,
// wrap or saturate behaviour, synchronous clear and a cascade terminal count.
module contador_carga_param #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned MAX_VAL   = 63,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit keeps the clamp comparison meaningful when MAX_VAL is all ones
  localparam int unsigned EXT_W = WIDTH + 1;

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RESET_VAL);
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_VAL);
  localparam logic             SAT_C   = (SATURATE != 0);

  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic             at_max;
  logic             at_zero;
  logic             data_over;

  assign at_max    = (out == MAX_C);
  assign at_zero   = (out == '0);
  assign data_over = ({1'b0, data} > MAX_EXT);

  // Next count and event pulses; priority clear > load > enable > hold
  always_comb begin
    out_nxt      = out;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (clear) begin
      out_nxt = RST_C;
    end else if (load) begin
      if (data_over) begin
        out_nxt      = MAX_C;
        load_err_nxt = 1'b1;
      end else begin
        out_nxt = data;
      end
    end else if (enable) begin
      if (up_down) begin
        // Bound is tested before incrementing so the adder never overflows
        if (at_max) begin
          if (!SAT_C) begin
            out_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          out_nxt = out + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          if (!SAT_C) begin
            out_nxt  = MAX_C;
            wrap_nxt = 1'b1;
          end
        end else begin
          out_nxt = out - WIDTH'(1);
        end
      end
    end
  end

  // Count register and one-cycle event pulses; reset also drops pending pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out      <= RST_C;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      out      <= out_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

  // Zero-latency terminal count so a following stage can count on the same edge
  assign tc = enable & ~clear & ~load & (up_down ? at_max : at_zero);

endmodule
